axis_pattern_gen: RTL
=====================

# axis_pattern_gen

AXI4-Stream video source that generates full frames of 24-bit RGB test patterns and drives the slave port of the DVI output stage. It runs in the pixel clock domain, emits pixels in raster order and marks the last pixel of each frame with `axis_tlast`. It is used for bring-up and as a fallback source when no frame buffer is present. Pattern and enable changes take effect only on frame boundaries, so the display never sees a torn frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line; ≥ 8, ≤ 2048.
- `V_ACTIVE`, 480: active lines per frame; ≥ 2, ≤ 2048.

Ports:
- `clk`  in  1  pixel clock; shared with the downstream `axis_aclk`.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  run request; sampled only at frame boundaries.
- `pattern_sel`  in  2  pattern select; sampled only at frame boundaries.
- `axis_tvalid`  out  1  pixel valid.
- `axis_tready`  in  1  downstream ready.
- `axis_tdata`  out  32  pixel: [31:24] = 0, [23:16] = R, [15:8] = G, [7:0] = B.
- `axis_tlast`  out  1  high with pixel (H_ACTIVE-1, V_ACTIVE-1).
- `frame_cnt`  out  8  count of completed frames; wraps 255→0.

## Operation
- Internal state:
  - `x` counter, 11 bits.
  - `y` counter, 11 bits.
  - `pat` register, 2 bits: latched pattern.
  - FSM with states IDLE and RUN.
- IDLE:
  - `axis_tvalid` = 0; x = y = 0.
  - When `enable` = 1, go to RUN on the next edge and latch `pat <= pattern_sel`.
- RUN:
  - `axis_tvalid` = 1 continuously.
  - A transfer is a cycle with `axis_tvalid & axis_tready`. Each transfer advances x.
  - When x = H_ACTIVE-1, x wraps to 0 and y increments.
  - On the transfer with x = H_ACTIVE-1 and y = V_ACTIVE-1 (end of frame):
    - x and y return to 0.
    - `frame_cnt` increments.
    - `pat <= pattern_sel`.
    - If `enable` = 0, go to IDLE; otherwise stay in RUN.
- Pixel function of (x, y, pat, frame_cnt):
  - pat 0, colour bars, 8 bars:
    - Bar index b = x / (H_ACTIVE/8), clamped to 7. H_ACTIVE/8 is an elaboration-time constant.
    - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - pat 1, grey ramp: R = G = B = x[7:0], wrapping every 256 pixels.
  - pat 2, checkerboard: white when x[5]^y[5] = 1, else black. Squares are 32×32.
  - pat 3, moving gradient:
    - R = x[7:0] + frame_cnt (mod 256).
    - G = y[7:0].
    - B = frame_cnt.
- `axis_tdata[31:24]` is always 0.

## Timing
- Reset values:
  - `axis_tvalid` = 0, `axis_tlast` = 0, `axis_tdata` = 0, `frame_cnt` = 0.
  - FSM = IDLE, x = y = 0, pat = 0.
- `axis_tdata`, `axis_tlast` and `axis_tvalid` are registers; no combinational path from `axis_tready`.
- Latency:
  - If `enable` is high at the edge after `rst` falls, `axis_tvalid` rises at the following edge.
  - The first pixel presented is (0,0) of the latched pattern.
- The pixel presented always corresponds to the current (x, y). The next pixel is registered in the same cycle as the transfer, so a stream with `axis_tready` held at 1 sustains one pixel per clock.
- Stall: while `axis_tvalid` = 1 and `axis_tready` = 0:
  - `axis_tdata`, `axis_tlast`, x, y and `frame_cnt` hold.
  - `axis_tvalid` stays 1. Once asserted, it never drops before the end-of-frame transfer.
- `enable` or `pattern_sel` changes mid-frame: ignored until the end-of-frame transfer.
- Transition to IDLE after the last pixel: `axis_tvalid` = 0 in the cycle after the `tlast` transfer, with no extra beat.
- Back-to-back frames: pixel (0,0) of the next frame is presented in the cycle immediately after the `tlast` transfer.
- `frame_cnt` updates in the same edge as the `tlast` transfer.
- `rst` asserted mid-frame: all outputs take their reset values immediately (asynchronously). After release the generator restarts at (0,0); the partial frame is not completed.

## Test plan
- Reset and start:
  - Stimulus: `rst` high, `enable` = 1, `axis_tready` = 1; release `rst`.
  - Required: `axis_tvalid` = 0 during reset and rises 1 cycle after release. First pixel is `axis_tdata` = 0x00FFFFFF (bar 0, pat 0).
- Full frame, default parameters:
  - Stimulus: `pattern_sel` = 0, `axis_tready` = 1.
  - Required:
    - Exactly 307200 transfers between `tlast` pulses.
    - Pixel x = 80 is 0x00FFFF00; x = 639 is 0x00000000.
    - `frame_cnt` = 1 after the first `tlast`.
- Backpressure:
  - Stimulus: pseudo-random `axis_tready` with about 50% duty; pattern 2.
  - Required:
    - `axis_tdata` and `axis_tlast` are stable while stalled.
    - The collected frame is bit-identical to the unstalled reference, e.g. pixel (32,0) = 0x00FFFFFF and (32,32) = 0.
- Frame-boundary sampling:
  - Stimulus: switch `pattern_sel` from 1 to 3 and drop `enable` mid-frame.
  - Required:
    - The rest of the frame remains a grey ramp; pixel (300,y) = 0x002C2C2C.
    - `axis_tvalid` = 0 the cycle after `tlast`.
    - Re-enable: the first frame uses pat 3 with B = `frame_cnt`.
- Mid-frame reset:
  - Stimulus: assert `rst` at pixel (100,50) for 3 cycles, then release.
  - Required:
    - Outputs go to reset values asynchronously, with `frame_cnt` = 0.
    - After release the first transfer is (0,0).
- Small frame and wrap:
  - Stimulus: H_ACTIVE = 8, V_ACTIVE = 2, pat 3, run 260 frames.
  - Required:
    - `tlast` on every 16th transfer.
    - `frame_cnt` wraps from 255 to 0.
    - Pixel (7,1) of frame 255 is 0x000601FF.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// AXI4-Stream RGB test-pattern source. Generates full frames in raster order,
// marks the last pixel with tlast, and only changes pattern/enable on frame
// boundaries so a frame is never torn.
module axis_pattern_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        axis_tvalid,
   input  logic        axis_tready,
   output logic [31:0] axis_tdata,
   output logic        axis_tlast,
   output logic [7:0]  frame_cnt
);

   localparam logic [10:0] XLast = 11'(H_ACTIVE - 1);
   localparam logic [10:0] YLast = 11'(V_ACTIVE - 1);
   localparam int unsigned BarW  = H_ACTIVE / 8;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [1:0]  pat_q, pat_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic        tvalid_q, tvalid_d;
   logic        tlast_q, tlast_d;
   logic [23:0] rgb_q, rgb_d;

   // RGB value of pixel (px, py) for a given pattern and frame count.
   function automatic logic [23:0] pixel_f(input logic [10:0] px, input logic [10:0] py,
                                           input logic [1:0] pp, input logic [7:0] fc);
      logic [10:0] bar;
      logic [2:0]  bar_idx;
      logic [23:0] rgb;
      bar     = px / 11'(BarW);
      // Remainder pixels past the eighth bar stay in the last (black) bar.
      bar_idx = (bar > 11'd7) ? 3'd7 : bar[2:0];
      rgb     = '0;
      case (pp)
         2'd0: begin
            unique case (bar_idx)
               3'd0:    rgb = 24'hFFFFFF;
               3'd1:    rgb = 24'hFFFF00;
               3'd2:    rgb = 24'h00FFFF;
               3'd3:    rgb = 24'h00FF00;
               3'd4:    rgb = 24'hFF00FF;
               3'd5:    rgb = 24'hFF0000;
               3'd6:    rgb = 24'h0000FF;
               default: rgb = 24'h000000;
            endcase
         end
         2'd1:    rgb = {px[7:0], px[7:0], px[7:0]};
         2'd2:    rgb = (px[5] ^ py[5]) ? 24'hFFFFFF : 24'h000000;
         default: rgb = {px[7:0] + fc, py[7:0], fc};
      endcase
      return rgb;
   endfunction

   // Next-state logic: raster counters, frame-boundary sampling, registered pixel.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      pat_d    = pat_q;
      fcnt_d   = fcnt_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      rgb_d    = rgb_q;
      case (state_q)
         StIdle: begin
            x_d      = '0;
            y_d      = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            rgb_d    = '0;
            if (enable) begin
               state_d  = StRun;
               pat_d    = pattern_sel;
               tvalid_d = 1'b1;
               // H_ACTIVE >= 8, so pixel (0,0) is never the last one.
               rgb_d    = pixel_f(11'd0, 11'd0, pattern_sel, fcnt_q);
            end
         end
         StRun: begin
            // tvalid is always high in StRun, so tready alone marks a transfer.
            if (axis_tready) begin
               if (x_q == XLast) begin
                  x_d = '0;
                  if (y_q == YLast) begin
                     y_d    = '0;
                     fcnt_d = fcnt_q + 8'd1;
                     pat_d  = pattern_sel;
                     if (!enable) begin
                        state_d = StIdle;
                     end
                  end else begin
                     y_d = y_q + 11'd1;
                  end
               end else begin
                  x_d = x_q + 11'd1;
               end
               tvalid_d = (state_d == StRun);
               rgb_d    = tvalid_d ? pixel_f(x_d, y_d, pat_d, fcnt_d) : 24'h000000;
               tlast_d  = tvalid_d && (x_d == XLast) && (y_d == YLast);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         x_q      <= '0;
         y_q      <= '0;
         pat_q    <= '0;
         fcnt_q   <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         rgb_q    <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         pat_q    <= pat_d;
         fcnt_q   <= fcnt_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         rgb_q    <= rgb_d;
      end
   end

   assign axis_tvalid = tvalid_q;
   assign axis_tdata  = {8'h00, rgb_q};
   assign axis_tlast  = tlast_q;
   assign frame_cnt   = fcnt_q;

endmodule
